bram_stream_reader: RTL
=======================

Name: bram_stream_reader

Overview:
- Single-clock read-side sequencer for an inferred simple-dual-port block RAM with a registered read port.
- Accepts a burst command (base address, length) and drives the RAM read address.
- Absorbs the RAM's fixed 1-cycle read latency and emits the words on a valid/ready stream with full backpressure support.
- Sits directly downstream of the RAM read port, in the read-clock domain.

Parameters:
DATA_WIDTH, 8, width of RAM word and stream data
ADDRESS_WIDTH, 10, RAM address width; depth is 2**ADDRESS_WIDTH

Ports:
clk  input  1  sole clock; rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  command strobe; sampled only in IDLE
base_addr  input  ADDRESS_WIDTH  first read address
length  input  ADDRESS_WIDTH+1  word count, 0..2**ADDRESS_WIDTH
ram_addr  output  ADDRESS_WIDTH  registered read address to RAM
ram_data  input  DATA_WIDTH  RAM registered output, holds mem[ram_addr sampled at previous edge]
m_data  output  DATA_WIDTH  stream data (skid FIFO head)
m_valid  output  1  stream valid
m_ready  input  1  stream ready; beat transfers when m_valid & m_ready
m_last  output  1  high with final beat of burst
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the burst is complete

Behaviour:
- Reset values: ram_addr=0, m_valid=0, m_last=0, busy=0, done=0, FIFO empty, in-flight pipe cleared, state IDLE. m_data is don't-care while m_valid=0.
- States:
  - IDLE: start=1 latches base_addr and length, then RUN. If length=0, go to DONE instead.
  - RUN: issue reads. After the last issue, go to DRAIN.
  - DRAIN: wait until in-flight=0 and FIFO empty, then DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- Issue:
  - On an issuing edge, ram_addr <= next address, remaining decrements, and a 2-stage in-flight shift register takes a 1.
  - Address = base_addr + i, modulo 2**ADDRESS_WIDTH, so bursts wrap from max to 0.
- Capture:
  - The in-flight stage-2 bit set means ram_data is valid this cycle.
  - The word is pushed into a 4-entry skid FIFO at the next edge, with its last flag.
- Latency: start accepted at edge E0 → ram_addr=base after E0 → RAM output valid after E1 → FIFO push at E2 → m_valid=1 after E2. First beat appears 2 cycles after start.
- Credit rule: issue only if (FIFO count + in-flight count − pop this cycle) < 4. This guarantees no overflow under arbitrary m_ready.
- Throughput: with m_ready held high, 1 beat per cycle, no bubbles after the first.
- ram_addr holds its value when not issuing. The RAM reads continuously, so only issue-tagged data is captured.
- Stream rules:
  - m_data, m_valid and m_last stay stable while m_valid & !m_ready.
  - m_last is asserted on exactly one beat per burst, the beat for i = length−1.
- Push and pop in the same cycle are legal; count is unchanged.
- done pulses the cycle after the m_last beat transfers. busy falls with the return to IDLE.
- rst asserted mid-burst: all outputs return to reset values immediately. In-flight and queued data are discarded, and no done pulse is produced.

Test Plan:
- Reset: assert rst during RUN with 2 words queued → m_valid=0, busy=0, done=0 immediately. After release, nothing emitted until a new start.
- Basic burst: RAM preloaded with mem[k]=k+0x10; start, base=5, length=4, m_ready=1 → beats 0x15, 0x16, 0x17, 0x18 on consecutive cycles; first beat 2 cycles after start; m_last on 0x18; done the following cycle.
- Backpressure: length=8, m_ready toggling 1,0,0,1,… and held low for 10 cycles → exact in-order sequence, no loss or duplication, FIFO count ≤4, m_data stable while stalled.
- Wrap: base=1022, length=4, ADDRESS_WIDTH=10 → ram_addr sequence 1022, 1023, 0, 1, with matching data.
- Length 0: start with length=0 → no m_valid; busy high for one cycle; done pulses 1 cycle after start. Full length 1024 → 1024 beats, single m_last.
- Start while busy: second start mid-burst with different base → ignored, first burst completes unchanged.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Read-side sequencer for a registered-output block RAM: issues a burst of
// addresses, absorbs the 1-cycle read latency and replays words on a valid/ready stream.
module bram_stream_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_data,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done
);

  localparam int FIFO_DEPTH = 4;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDRESS_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDRESS_WIDTH:0]   LEN_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] next_addr_q;
  logic [ADDRESS_WIDTH:0]   remaining_q;

  logic                     vld_p1, vld_p2;
  logic                     last_p1, last_p2;

  logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    fifo_last;
  logic [1:0]               wr_ptr_q, rd_ptr_q;
  logic [2:0]               count_q;

  logic                     issue, issue_last;
  logic [ADDRESS_WIDTH-1:0] issue_addr;
  logic                     push, pop;
  logic [2:0]               inflight, occupancy;
  logic                     credit_ok;

  assign m_valid = (count_q != 3'd0);
  assign m_data  = fifo_data[rd_ptr_q];
  assign m_last  = m_valid & fifo_last[rd_ptr_q];
  assign pop     = m_valid & m_ready;
  assign push    = vld_p2;

  // A slot freed by this cycle's pop may be reused by this cycle's issue.
  assign inflight  = {2'b00, vld_p1} + {2'b00, vld_p2};
  assign occupancy = count_q + inflight - {2'b00, pop};
  assign credit_ok = (occupancy < 3'(FIFO_DEPTH));

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = next_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == LEN_ZERO) begin
            state_d = DONE;
          end else begin
            // First read goes out on the accepting edge to keep start-to-data at two cycles.
            issue      = 1'b1;
            issue_addr = base_addr;
            issue_last = (length == LEN_ONE);
            state_d    = issue_last ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (remaining_q == LEN_ONE);
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!vld_p1 && !vld_p2 && (count_q == {2'b00, pop})) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: address issue; p1 -> p2: RAM output valid; p2 -> FIFO: capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr    <= '0;
      next_addr_q <= '0;
      remaining_q <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
    end else begin
      vld_p1 <= issue;
      vld_p2 <= vld_p1;
      if (issue) begin
        ram_addr    <= issue_addr;
        next_addr_q <= issue_addr + ADDR_ONE;
        remaining_q <= (state_q == IDLE) ? (length - LEN_ONE) : (remaining_q - LEN_ONE);
      end
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    last_p1 <= issue_last;
    last_p2 <= last_p1;
    if (push) begin
      fifo_data[wr_ptr_q] <= ram_data;
      fifo_last[wr_ptr_q] <= last_p2;
    end
  end

endmodule
